// File: rtl/admm_pkg.sv
// admm_pkg: shared element width, ADMM stage FSM states and saturating lane arithmetic
package admm_pkg;
  localparam int ELEM_WIDTH = 16;
  localparam logic signed [ELEM_WIDTH-1:0] ELEM_MAX = {1'b0, {(ELEM_WIDTH-1){1'b1}}};
  localparam logic signed [ELEM_WIDTH-1:0] ELEM_MIN = {1'b1, {(ELEM_WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, RUN_Y, DRAIN_Y, RUN_G, DRAIN_G, DONE} state_t;
  function automatic logic signed [ELEM_WIDTH-1:0] sat_sum3(
    input logic signed [ELEM_WIDTH-1:0] a,
    input logic signed [ELEM_WIDTH-1:0] b,
    input logic signed [ELEM_WIDTH-1:0] c
  );
    logic signed [ELEM_WIDTH+1:0] s;
    s = (ELEM_WIDTH+2)'(a) + (ELEM_WIDTH+2)'(b) - (ELEM_WIDTH+2)'(c);
    return s > (ELEM_WIDTH+2)'(ELEM_MAX) ? ELEM_MAX :
           s < (ELEM_WIDTH+2)'(ELEM_MIN) ? ELEM_MIN : s[ELEM_WIDTH-1:0];
  endfunction
  function automatic logic [ELEM_WIDTH-1:0] sat_absdiff(
    input logic signed [ELEM_WIDTH-1:0] b,
    input logic signed [ELEM_WIDTH-1:0] c
  );
    logic signed [ELEM_WIDTH:0] d;
    logic [ELEM_WIDTH:0] m;
    d = (ELEM_WIDTH+1)'(b) - (ELEM_WIDTH+1)'(c);
    m = d[ELEM_WIDTH] ? -d : d;
    return m > (ELEM_WIDTH+1)'(ELEM_MAX) ? ELEM_MAX : m[ELEM_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/dual_lane_alu.sv
// dual_lane_alu: one lane of the dual update, saturated a + b - c and |b - c|
module dual_lane_alu
  import admm_pkg::*;
(
  input  logic signed [ELEM_WIDTH-1:0] i_a,
  input  logic signed [ELEM_WIDTH-1:0] i_b,
  input  logic signed [ELEM_WIDTH-1:0] i_c,
  output logic signed [ELEM_WIDTH-1:0] o_sum,
  output logic        [ELEM_WIDTH-1:0] o_absd
);
  assign o_sum  = sat_sum3(i_a, i_b, i_c);
  assign o_absd = sat_absdiff(i_b, i_c);
endmodule

// File: rtl/dual_update.sv
// dual_update: ADMM dual update y += u - z, g += x - v in place, with primal/dual residual tracking
module dual_update
  import admm_pkg::*;
#(
  parameter int STATE_DIM        = 12,
  parameter int INPUT_DIM        = 4,
  parameter int HORIZON          = 30,
  parameter int ADDR_WIDTH       = 9,
  parameter int DATA_WIDTH_INPUT = INPUT_DIM * ELEM_WIDTH,
  parameter int DATA_WIDTH_STATE = STATE_DIM * ELEM_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [31:0]                 active_horizon,
  output logic [ADDR_WIDTH-1:0]       u_rdaddress,
  output logic [ADDR_WIDTH-1:0]       z_rdaddress,
  output logic [ADDR_WIDTH-1:0]       z_prev_rdaddress,
  output logic [ADDR_WIDTH-1:0]       y_rdaddress,
  input  logic [DATA_WIDTH_INPUT-1:0] u_data_out,
  input  logic [DATA_WIDTH_INPUT-1:0] z_data_out,
  input  logic [DATA_WIDTH_INPUT-1:0] z_prev_data_out,
  input  logic [DATA_WIDTH_INPUT-1:0] y_data_out,
  output logic [ADDR_WIDTH-1:0]       y_wraddress,
  output logic [DATA_WIDTH_INPUT-1:0] y_data_in,
  output logic                        y_wren,
  output logic [ADDR_WIDTH-1:0]       x_rdaddress,
  output logic [ADDR_WIDTH-1:0]       v_rdaddress,
  output logic [ADDR_WIDTH-1:0]       g_rdaddress,
  input  logic [DATA_WIDTH_STATE-1:0] x_data_out,
  input  logic [DATA_WIDTH_STATE-1:0] v_data_out,
  input  logic [DATA_WIDTH_STATE-1:0] g_data_out,
  output logic [ADDR_WIDTH-1:0]       g_wraddress,
  output logic [DATA_WIDTH_STATE-1:0] g_data_in,
  output logic                        g_wren,
  output logic [ELEM_WIDTH-1:0]       primal_residual,
  output logic [ELEM_WIDTH-1:0]       dual_residual,
  output logic                        done
);
  localparam int EW = ELEM_WIDTH;
  localparam int P  = 1 << $clog2(STATE_DIM > INPUT_DIM ? STATE_DIM : INPUT_DIM);
  typedef logic [EW-1:0] elem_t;
  function automatic elem_t max_tree(input elem_t leaf [P]);
    elem_t n [2*P];
    n[0] = '0;
    for (int i = 0; i < P; i++) n[P+i] = leaf[i];
    for (int i = P - 1; i > 0; i--) n[i] = n[2*i] > n[2*i+1] ? n[2*i] : n[2*i+1];
    return n[1];
  endfunction
  state_t r_state;
  logic [ADDR_WIDTH-1:0] r_k, r_a1, r_ny, r_ng, w_h, w_ny;
  logic r_dr, r_v1y, r_v1g;
  logic [DATA_WIDTH_INPUT-1:0] w_ynew;
  logic [DATA_WIDTH_STATE-1:0] w_gnew;
  elem_t w_uz [P], w_zz [P], w_xv [P], w_pleaf [P], w_dleaf [P];
  elem_t w_pmax, w_dmax;
  assign w_h  = active_horizon > 32'(HORIZON) ? ADDR_WIDTH'(HORIZON) : active_horizon[ADDR_WIDTH-1:0];
  assign w_ny = w_h > 1 ? w_h - 1'b1 : '0;
  assign {u_rdaddress, z_rdaddress, z_prev_rdaddress, y_rdaddress} = {4{r_k}};
  assign {x_rdaddress, v_rdaddress, g_rdaddress} = {3{r_k}};
  assign done = r_state == DONE;
  // Lanes beyond each phase's width read as zero so one tree serves both phases
  for (genvar j = 0; j < P; j++) begin : g_lane
    if (j < INPUT_DIM) begin : g_y
      dual_lane_alu u_alu (
        .i_a(y_data_out[j*EW +: EW]), .i_b(u_data_out[j*EW +: EW]), .i_c(z_data_out[j*EW +: EW]),
        .o_sum(w_ynew[j*EW +: EW]), .o_absd(w_uz[j])
      );
      assign w_zz[j] = sat_absdiff(z_data_out[j*EW +: EW], z_prev_data_out[j*EW +: EW]);
    end else begin : g_ny
      assign w_uz[j] = '0;
      assign w_zz[j] = '0;
    end
    if (j < STATE_DIM) begin : g_g
      dual_lane_alu u_alu (
        .i_a(g_data_out[j*EW +: EW]), .i_b(x_data_out[j*EW +: EW]), .i_c(v_data_out[j*EW +: EW]),
        .o_sum(w_gnew[j*EW +: EW]), .o_absd(w_xv[j])
      );
    end else begin : g_ng
      assign w_xv[j] = '0;
    end
    assign w_pleaf[j] = r_v1y ? w_uz[j] : r_v1g ? w_xv[j] : '0;
    assign w_dleaf[j] = r_v1y ? w_zz[j] : '0;
  end
  assign w_pmax = max_tree(w_pleaf);
  assign w_dmax = max_tree(w_dleaf);
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_k             <= '0;
      r_a1            <= '0;
      r_ny            <= '0;
      r_ng            <= '0;
      r_dr            <= 1'b0;
      r_v1y           <= 1'b0;
      r_v1g           <= 1'b0;
      y_wren          <= 1'b0;
      y_wraddress     <= '0;
      y_data_in       <= '0;
      g_wren          <= 1'b0;
      g_wraddress     <= '0;
      g_data_in       <= '0;
      primal_residual <= '0;
      dual_residual   <= '0;
    end else begin
      r_v1y  <= r_state == RUN_Y;
      r_v1g  <= r_state == RUN_G;
      r_a1   <= r_k;
      y_wren <= r_v1y;
      g_wren <= r_v1g;
      if (r_v1y) begin
        y_wraddress   <= r_a1;
        y_data_in     <= w_ynew;
        dual_residual <= w_dmax > dual_residual ? w_dmax : dual_residual;
      end
      if (r_v1g) begin
        g_wraddress <= r_a1;
        g_data_in   <= w_gnew;
      end
      if (r_v1y || r_v1g) primal_residual <= w_pmax > primal_residual ? w_pmax : primal_residual;
      case (r_state)
        IDLE: if (start) begin
          primal_residual <= '0;
          dual_residual   <= '0;
          r_ny            <= w_ny;
          r_ng            <= w_h;
          r_k             <= '0;
          r_state         <= w_ny != 0 ? RUN_Y : w_h != 0 ? RUN_G : DONE;
        end
        RUN_Y: begin
          r_k     <= r_k == r_ny - 1'b1 ? '0 : r_k + 1'b1;
          r_state <= r_k == r_ny - 1'b1 ? DRAIN_Y : RUN_Y;
        end
        DRAIN_Y: begin
          r_dr    <= !r_dr;
          r_state <= r_dr ? RUN_G : DRAIN_Y;
        end
        RUN_G: begin
          r_k     <= r_k == r_ng - 1'b1 ? '0 : r_k + 1'b1;
          r_state <= r_k == r_ng - 1'b1 ? DRAIN_G : RUN_G;
        end
        DRAIN_G: begin
          r_dr    <= !r_dr;
          r_state <= r_dr ? DONE : DRAIN_G;
        end
        DONE:    r_state <= start ? DONE : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dual_update.sv
// tb_dual_update: directed self-checking bench for dual_update with synchronous-read RAM models
module tb_dual_update;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, ld = 1'b0, clr = 1'b0;
  logic [31:0] active_horizon = '0;
  logic [8:0] u_rdaddress, z_rdaddress, z_prev_rdaddress, y_rdaddress, y_wraddress;
  logic [8:0] x_rdaddress, v_rdaddress, g_rdaddress, g_wraddress;
  logic [63:0] u_data_out = '0, z_data_out = '0, z_prev_data_out = '0, y_data_out, y_data_in, y_fill;
  logic [191:0] x_data_out = '0, v_data_out = '0, g_data_out, g_data_in, g_fill;
  logic y_wren, g_wren, done;
  logic [15:0] primal_residual, dual_residual;
  logic [63:0] ymem [512];
  logic [191:0] gmem [512];
  int ycnt, gcnt, cyc;
  int n_chk = 0, n_fail = 0;
  bit ybad, gbad;

  dual_update dut (
    .clk(clk), .rst(rst), .start(start), .active_horizon(active_horizon),
    .u_rdaddress(u_rdaddress), .z_rdaddress(z_rdaddress),
    .z_prev_rdaddress(z_prev_rdaddress), .y_rdaddress(y_rdaddress),
    .u_data_out(u_data_out), .z_data_out(z_data_out),
    .z_prev_data_out(z_prev_data_out), .y_data_out(y_data_out),
    .y_wraddress(y_wraddress), .y_data_in(y_data_in), .y_wren(y_wren),
    .x_rdaddress(x_rdaddress), .v_rdaddress(v_rdaddress), .g_rdaddress(g_rdaddress),
    .x_data_out(x_data_out), .v_data_out(v_data_out), .g_data_out(g_data_out),
    .g_wraddress(g_wraddress), .g_data_in(g_data_in), .g_wren(g_wren),
    .primal_residual(primal_residual), .dual_residual(dual_residual), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    y_data_out <= ymem[y_rdaddress];
    g_data_out <= gmem[g_rdaddress];
    if (ld) begin
      for (int i = 0; i < 512; i++) begin
        ymem[i] <= y_fill;
        gmem[i] <= g_fill;
      end
    end else begin
      if (y_wren) ymem[y_wraddress] <= y_data_in;
      if (g_wren) gmem[g_wraddress] <= g_data_in;
    end
  end

  // Write counters; addresses must run 0,1,2.. in order within each phase
  always @(posedge clk) begin
    if (clr) begin
      ycnt = 0;
      gcnt = 0;
      ybad = 1'b0;
      gbad = 1'b0;
    end else begin
      if (y_wren) begin
        if (32'(y_wraddress) != ycnt) ybad = 1'b1;
        ycnt++;
      end
      if (g_wren) begin
        if (32'(g_wraddress) != gcnt) gbad = 1'b1;
        gcnt++;
      end
    end
  end

  function automatic logic [63:0] rep4(input logic [15:0] v);
    return {4{v}};
  endfunction
  function automatic logic [191:0] rep12(input logic [15:0] v);
    return {12{v}};
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] ex);
    n_chk++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, ex);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] yv, input logic [191:0] gv);
    y_fill = yv;
    g_fill = gv;
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic set_in(input logic [63:0] u, z, zp, input logic [191:0] x, v);
    u_data_out = u;
    z_data_out = z;
    z_prev_data_out = zp;
    x_data_out = x;
    v_data_out = v;
  endtask

  // hold=1 keeps start high into DONE; hold=0 releases it and re-pulses it in cycle 40
  task automatic run(input int h, input bit hold);
    active_horizon = h;
    start = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    if (!hold) start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (!hold) start = (cyc == 40);
      tick();
      cyc++;
    end
    if (hold) begin
      tick();
      check("done_held", 192'(done), 192'(1));
      start = 1'b0;
    end
    tick();
    check("done_drop", 192'(done), 192'(0));
  endtask

  task automatic expect_run(input string t, input int c, input int ny, input int ng);
    check({t, "_cycles"}, 192'(cyc), 192'(c));
    check({t, "_ywrites"}, 192'(ycnt), 192'(ny));
    check({t, "_gwrites"}, 192'(gcnt), 192'(ng));
    check({t, "_addr_seq"}, 192'({ybad, gbad}), 192'(0));
  endtask

  initial begin
    logic [191:0] xl;
    repeat (3) tick();
    check("rst_done", 192'(done), 192'(0));
    check("rst_y_wren", 192'(y_wren), 192'(0));
    check("rst_g_wren", 192'(g_wren), 192'(0));
    check("rst_y_rdaddr", 192'(y_rdaddress), 192'(0));
    check("rst_g_rdaddr", 192'(g_rdaddress), 192'(0));
    check("rst_y_wraddr", 192'(y_wraddress), 192'(0));
    check("rst_y_data", 192'(y_data_in), 192'(0));
    check("rst_g_data", g_data_in, 192'(0));
    check("rst_primal", 192'(primal_residual), 192'(0));
    check("rst_dual", 192'(dual_residual), 192'(0));
    rst = 1'b1;

    set_in(rep4(16'd100), rep4(16'd40), rep4(16'd30), rep12(16'd7), rep12(16'd10));
    load(rep4(16'd5), rep12(-16'sd2));
    run(30, 1'b1);
    expect_run("h30", 64, 29, 30);
    check("h30_primal", 192'(primal_residual), 192'(60));
    check("h30_dual", 192'(dual_residual), 192'(10));
    check("h30_y0", 192'(ymem[0]), 192'(rep4(16'd65)));
    check("h30_y28", 192'(ymem[28]), 192'(rep4(16'd65)));
    check("h30_y29_untouched", 192'(ymem[29]), 192'(rep4(16'd5)));
    check("h30_g0", gmem[0], rep12(-16'sd5));
    check("h30_g29", gmem[29], rep12(-16'sd5));
    check("h30_g30_untouched", gmem[30], rep12(-16'sd2));

    xl = '0;
    for (int j = 0; j < 12; j++) xl[j*16 +: 16] = 16'(j * 100);
    set_in({16'd40, 16'd30, 16'd20, 16'd10}, '0, {-16'sd20, -16'sd15, -16'sd10, -16'sd5}, xl, '0);
    load('0, '0);
    run(3, 1'b1);
    expect_run("lanes", 10, 2, 3);
    check("lanes_y1", 192'(ymem[1]), 192'({16'd40, 16'd30, 16'd20, 16'd10}));
    check("lanes_y2_untouched", 192'(ymem[2]), 192'(0));
    check("lanes_g2", gmem[2], xl);
    check("lanes_primal", 192'(primal_residual), 192'(1100));
    check("lanes_dual", 192'(dual_residual), 192'(20));

    set_in(rep4(16'd1000), rep4(-16'sd1000), rep4(-16'sd1000), '0, '0);
    load(rep4(16'd32000), '0);
    run(2, 1'b1);
    expect_run("satp", 8, 1, 2);
    check("satp_y0", 192'(ymem[0]), 192'(rep4(16'h7fff)));
    check("satp_y1_untouched", 192'(ymem[1]), 192'(rep4(16'd32000)));
    check("satp_primal", 192'(primal_residual), 192'(2000));
    check("satp_dual", 192'(dual_residual), 192'(0));

    set_in(rep4(-16'sd1000), rep4(16'd1000), rep4(16'd1000), '0, '0);
    load(rep4(-16'sd32000), '0);
    run(2, 1'b1);
    check("satn_y0", 192'(ymem[0]), 192'(rep4(16'h8000)));
    check("satn_primal", 192'(primal_residual), 192'(2000));

    set_in(rep4(16'h7fff), rep4(16'h8000), rep4(16'h7fff), '0, '0);
    load('0, '0);
    run(2, 1'b1);
    check("ovf_y0", 192'(ymem[0]), 192'(rep4(16'h7fff)));
    check("ovf_primal", 192'(primal_residual), 192'(32767));
    check("ovf_dual", 192'(dual_residual), 192'(32767));

    set_in(rep4(16'd100), rep4(16'd40), rep4(16'd30), rep12(16'd7), rep12(16'd10));
    load(rep4(16'd5), rep12(-16'sd2));
    run(1, 1'b1);
    expect_run("h1", 4, 0, 1);
    check("h1_g0", gmem[0], rep12(-16'sd5));
    check("h1_g1_untouched", gmem[1], rep12(-16'sd2));
    check("h1_y0_untouched", 192'(ymem[0]), 192'(rep4(16'd5)));
    check("h1_primal", 192'(primal_residual), 192'(3));
    check("h1_dual", 192'(dual_residual), 192'(0));

    run(0, 1'b1);
    expect_run("h0", 1, 0, 0);
    check("h0_primal", 192'(primal_residual), 192'(0));
    check("h0_dual", 192'(dual_residual), 192'(0));

    load(rep4(16'd5), rep12(-16'sd2));
    run(100, 1'b1);
    expect_run("h100", 64, 29, 30);
    check("h100_primal", 192'(primal_residual), 192'(60));
    check("h100_dual", 192'(dual_residual), 192'(10));
    check("h100_g30_untouched", gmem[30], rep12(-16'sd2));

    load(rep4(16'd5), rep12(-16'sd2));
    active_horizon = 30;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("prerst_y_wren", 192'(y_wren), 192'(1));
    rst = 1'b0;
    tick();
    check("midrst_y_wren", 192'(y_wren), 192'(0));
    check("midrst_y_rdaddr", 192'(y_rdaddress), 192'(0));
    check("midrst_y_wraddr", 192'(y_wraddress), 192'(0));
    check("midrst_y_data", 192'(y_data_in), 192'(0));
    check("midrst_primal", 192'(primal_residual), 192'(0));
    check("midrst_done", 192'(done), 192'(0));
    rst = 1'b1;
    run(1, 1'b1);
    expect_run("postrst", 4, 0, 1);

    load(rep4(16'd5), rep12(-16'sd2));
    run(30, 1'b0);
    expect_run("repulse", 64, 29, 30);
    check("repulse_g29", gmem[29], rep12(-16'sd5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dual_update.md
# dual_update

ADMM dual-variable update stage; consumes the z/v auxiliary trajectories and z_prev snapshot written by the slack (projection) stage. Computes y ← y + u − z over the input trajectory and g ← g + x − v over the state trajectory, with ρ = 1. Writes y and g back in place. Reports primal and dual residuals to the ADMM iteration controller.

## Interface
- STATE_DIM, 12: state vector length (nx)
- INPUT_DIM, 4: input vector length (nu)
- HORIZON, 30: maximum horizon N
- ELEM_WIDTH, 16: signed fixed-point element width
- DATA_WIDTH_INPUT, 64: INPUT_DIM*ELEM_WIDTH; one packed u/z/z_prev/y word per timestep
- DATA_WIDTH_STATE, 192: STATE_DIM*ELEM_WIDTH; one packed x/v/g word per timestep
- ADDR_WIDTH, 9: memory address width; address = timestep k
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-low
- start  in  1  level; sampled in IDLE only
- active_horizon  in  32  horizon H; values > HORIZON clamp to HORIZON
- u_rdaddress, z_rdaddress, z_prev_rdaddress, y_rdaddress  out  ADDR_WIDTH each  input-side read addresses; always driven to the same k
- u_data_out, z_data_out, z_prev_data_out, y_data_out  in  DATA_WIDTH_INPUT each  read data
- y_wraddress / y_data_in / y_wren  out  ADDR_WIDTH / DATA_WIDTH_INPUT / 1  y write port
- x_rdaddress, v_rdaddress, g_rdaddress  out  ADDR_WIDTH each  state-side read addresses; same k
- x_data_out, v_data_out, g_data_out  in  DATA_WIDTH_STATE each  read data
- g_wraddress / g_data_in / g_wren  out  ADDR_WIDTH / DATA_WIDTH_STATE / 1  g write port
- primal_residual  out  ELEM_WIDTH  unsigned max over all lanes of |u−z| and |x−v|
- dual_residual  out  ELEM_WIDTH  unsigned max over all lanes of |z−z_prev|
- done  out  1  completion level

## Operation
- Reset: state IDLE; every output, including addresses, data, wren, residuals and done, is 0.
- Phase sizes: Ny = H−1 (0 if H ≤ 1) for the y phase; Ng = H for the g phase.
- States: IDLE → RUN_Y → DRAIN_Y → RUN_G → DRAIN_G → DONE → IDLE.
  - A phase with count 0 is skipped entirely, with no drain.
  - H = 0 goes IDLE → DONE.
- RUN_*: issue one read address per cycle, k = 0 .. N−1.
- DRAIN_*: fixed 2 cycles to flush the pipeline. Phases never overlap.
- Per-lane arithmetic on signed ELEM_WIDTH values:
  - Sum a + b − c computed at ELEM_WIDTH+2 bits.
  - Result saturates to [−2^(ELEM_WIDTH−1), 2^(ELEM_WIDTH−1)−1].
  - |b − c| saturates to 2^(ELEM_WIDTH−1)−1.
- Lane j occupies bits [j*ELEM_WIDTH +: ELEM_WIDTH].
- Residual accumulators are cleared when start is accepted and updated with a running max per element. Outputs are held from DONE until the next accepted start.
- DONE: done = 1, all wren = 0. Stays in DONE while start = 1; returns to IDLE (done → 0) on the first cycle start = 0.
- start while not IDLE is ignored.
- rst low mid-run: at that edge all state returns to reset values and wren drops the same edge. Partially updated memory is not restored.

## Timing
- RAM model: synchronous read. data_out for address k is valid in the cycle after rdaddress = k.
- Pipeline, with rdaddress = k in cycle c:
  - Data for k is valid in cycle c+1 and registered at the end of c+1.
  - wren = 1, wraddress = k, data_in = result during cycle c+2.
- Throughput: 1 timestep per cycle. The read of k+1 and the write of k target different addresses (dual-port RAM).
- Cycle count: the start-sampling edge is E0, and cycle 1 is the first cycle after it. done rises in cycle 1 + Σ over non-empty phases of (N+2).
  - H = 30 → cycle 64.
  - H = 1 → cycle 4.
  - H = 0 → cycle 1.
- Each wren is high for exactly N cycles per phase, with consecutive wraddress values.

## Structure
- Shared package admm_pkg holds: ELEM_WIDTH, the state enum, and the saturating functions sat_sum3 and sat_absdiff.
- Sub-module dual_lane_alu (combinational) computes one lane: a + b − c saturated, and |b − c|.
  - Instantiate INPUT_DIM lanes for the y phase and STATE_DIM lanes for the g phase via generate.
- A max-reduction tree feeds the residual registers.

## Test plan
- H = 30, u = 100, z = 40, y = 5, x = 7, v = 10, g = −2 in all lanes; z_prev = 30 → y = 65 at k = 0..28, g = −5 at k = 0..29; primal = 60, dual = 10; done in cycle 64.
- Saturation: y = 32000, u = 1000, z = −1000 → y written 32767. y = −32000, u = −1000, z = 1000 → −32768. |u − z| overflow → primal = 32767.
- H = 1 → no y_wren; one g write at k = 0; done in cycle 4. H = 0 → no writes; done in cycle 1; residuals 0.
- H = 100 with HORIZON = 30 → behaves as H = 30. start held high through DONE → done stays 1; drop start → done = 0 next cycle.
- rst low in cycle 10 of RUN_Y → next cycle all outputs 0, state IDLE. A subsequent start completes normally.
- start re-pulsed during RUN_G → ignored; write count and done timing unchanged.
